mem_port_arbiter: RTL

Shares the single memory port between the core's instruction-fetch path and its load/store path, one transaction at a time, with round-robin arbitration on contention. It also decodes one memory-mapped UART address. Data-side writes to that address become a one-cycle `tx_start` pulse and never reach memory. It sits between the multi-cycle core and the block RAM, replacing the core's direct `iaddr`/`raddr`/`wen` wiring.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response channels, block RAM port and UART hooks of mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding core/memory/UART.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic              m_wen;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata, tx_busy,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_wen, m_wdata, tx_start, tx_data
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata, tx_busy,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           m_addr, m_wen, m_wdata, tx_start, tx_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// with a single memory-mapped UART address decoded on the data side.
module mem_port_arbiter #(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        READ_LATENCY = 1,
  parameter logic [ADDR_W-1:0]  UART_ADDR    = ADDR_W'(32'hFFFF_FF00)
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_f_q, last_f_d;
  logic                own_d_q, own_d_d;
  logic                uart_rd_q, uart_rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic                f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic                m_wen_q, m_wen_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;

  logic                d_is_uart_c, d_elig_c, pick_d_c;
  logic [DATA_W-1:0]   rd_word_c;

  // A UART access may only proceed while the transmitter is free.
  assign d_is_uart_c = (bus.d_addr == UART_ADDR);
  assign d_elig_c    = bus.d_req && !(d_is_uart_c && bus.tx_busy);
  assign pick_d_c    = d_elig_c && (!bus.f_req || last_f_q);
  assign rd_word_c   = uart_rd_q ? {{(DATA_W-1){1'b0}}, bus.tx_busy} : bus.m_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_f_q   <= 1'b1;
      own_d_q    <= 1'b0;
      uart_rd_q  <= 1'b0;
      cnt_q      <= '0;
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
      m_addr_q   <= '0;
      m_wen_q    <= 1'b0;
      m_wdata_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_f_q   <= last_f_d;
      own_d_q    <= own_d_d;
      uart_rd_q  <= uart_rd_d;
      cnt_q      <= cnt_d;
      f_gnt_q    <= f_gnt_d;
      d_gnt_q    <= d_gnt_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_addr_q   <= m_addr_d;
      m_wen_q    <= m_wen_d;
      m_wdata_q  <= m_wdata_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_f_d   = last_f_q;
    own_d_d    = own_d_q;
    uart_rd_d  = uart_rd_q;
    cnt_d      = cnt_q;
    f_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    f_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_addr_d   = m_addr_q;
    m_wen_d    = 1'b0;
    m_wdata_d  = m_wdata_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      IDLE: begin
        if (pick_d_c) begin
          d_gnt_d   = 1'b1;
          last_f_d  = 1'b0;
          own_d_d   = 1'b1;
          cnt_d     = '0;
          m_addr_d  = bus.d_addr;
          uart_rd_d = 1'b0;
          if (bus.d_we) begin
            state_d = WRITE;
            if (d_is_uart_c) begin
              tx_start_d = 1'b1;
              tx_data_d  = bus.d_wdata[7:0];
            end else begin
              m_wen_d   = 1'b1;
              m_wdata_d = bus.d_wdata;
            end
          end else begin
            state_d   = READ;
            uart_rd_d = d_is_uart_c;
          end
        end else if (bus.f_req) begin
          f_gnt_d   = 1'b1;
          last_f_d  = 1'b1;
          own_d_d   = 1'b0;
          cnt_d     = '0;
          m_addr_d  = bus.f_addr;
          uart_rd_d = 1'b0;
          state_d   = READ;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        // UART status reads skip the memory latency entirely.
        if (uart_rd_q || (cnt_q == CNT_W'(READ_LATENCY))) begin
          state_d = RESP;
          if (own_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = rd_word_c;
          end else begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = rd_word_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.f_gnt    = f_gnt_q;
  assign bus.d_gnt    = d_gnt_q;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wen    = m_wen_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule
